// File: rtl/tt_um_hsc_tdc.sv
// Time-to-digital converter: a launch edge travels down a 127-tap shift line and a capture
// strobe snapshots the line; uo_out reports the Hamming weight of the snapshot with a valid pulse.
module tt_um_hsc_tdc (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned LINE_W = 127;
   localparam int unsigned HW_W   = 7;
   localparam int unsigned SYNC_W = 3;

   logic [SYNC_W-1:0] launch_sync;
   logic [SYNC_W-1:0] capture_sync;
   logic              launch_stb;
   logic              capture_stb;
   logic              src;
   logic              din;
   logic              lreg;
   logic [LINE_W-1:0] tap;
   logic [LINE_W-1:0] cap;
   logic              cap_pend;
   logic [HW_W-1:0]   cap_cnt;
   logic [HW_W-1:0]   hw;
   logic              valid;
   logic              unused_ok;

   // Bits [1:0] form the two-stage synchronizer, bit [2] remembers the previous synchronized level.
   assign launch_stb  = launch_sync[1]  & ~launch_sync[2];
   assign capture_stb = capture_sync[1] & ~capture_sync[2];

   assign src = ui_in[2] ? ui_in[5] : ui_in[4];
   assign din = ui_in[3] ? src : lreg;

   always_comb begin
      cap_cnt = '0;
      for (int unsigned i = 0; i < LINE_W; i++) begin
         cap_cnt = cap_cnt + HW_W'(cap[i]);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         launch_sync  <= '0;
         capture_sync <= '0;
         lreg         <= 1'b0;
         tap          <= '0;
         cap          <= '0;
         cap_pend     <= 1'b0;
         hw           <= '0;
      end else if (ena) begin
         launch_sync  <= {launch_sync[SYNC_W-2:0], ui_in[0]};
         capture_sync <= {capture_sync[SYNC_W-2:0], ui_in[1]};
         if (launch_stb) begin
            lreg <= src;
         end
         tap <= {tap[LINE_W-2:0], din};
         if (capture_stb) begin
            cap <= tap;
         end
         cap_pend <= capture_stb;
         if (cap_pend) begin
            hw <= cap_cnt;
         end
      end
   end

   // Valid rises only on the edge that actually loads hw, so a frozen pipeline never stretches it.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         valid <= 1'b0;
      end else begin
         valid <= ena & cap_pend;
      end
   end

   assign uo_out    = {valid, hw};
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unused_ok = &{1'b0, uio_in, ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_hsc_tdc.sv
// Scoreboard bench for tt_um_hsc_tdc: a per-edge history model predicts each capture's Hamming
// weight, and a negedge monitor checks every valid pulse and the held output value.
module tb_tt_um_hsc_tdc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors     = 0;
   int miscompares = 0;

   int       exp_q[$];
   bit [7:0] ui_h[$];
   bit       din_h[$];
   bit       m_lreg;
   int       last_hw;

   always #5 clk = ~clk;

   tt_um_hsc_tdc dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // A strobe acts on edge n when the pin was sampled 1 two enabled edges earlier and 0 three earlier.
   function automatic bit rose(input int b);
      int n;
      bit cur;
      bit prv;
      n   = ui_h.size();
      cur = (n >= 2) ? ui_h[n-2][b] : 1'b0;
      prv = (n >= 3) ? ui_h[n-3][b] : 1'b0;
      return cur & ~prv;
   endfunction

   // Reference model: capture result = ones among the last 127 line inputs before the capture edge.
   always @(posedge clk) begin
      if (rst_n) begin
         ui_h.delete();
         din_h.delete();
         exp_q.delete();
         m_lreg = 1'b0;
      end else if (ena) begin
         bit m_src;
         bit m_din;
         int ones;
         m_src = ui_in[2] ? ui_in[5] : ui_in[4];
         m_din = ui_in[3] ? m_src : m_lreg;
         if (rose(1)) begin
            ones = 0;
            for (int k = 0; k < 127 && k < din_h.size(); k++) begin
               ones += int'(din_h[din_h.size()-1-k]);
            end
            exp_q.push_back(ones);
         end
         if (rose(0)) m_lreg = m_src;
         din_h.push_back(m_din);
         ui_h.push_back(ui_in);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         last_hw = 0;
         vectors++;
         if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got uo=%h uio_out=%h uio_oe=%h, want 00 00 00",
                     uo_out, uio_out, uio_oe);
         end
      end else begin
         vectors++;
         if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            miscompares++;
            $display("FAIL uio_const: got uio_out=%h uio_oe=%h, want 00 00", uio_out, uio_oe);
         end
         if (uo_out[7] === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_valid: got valid with hw=%0d, want no valid", uo_out[6:0]);
            end else begin
               last_hw = exp_q.pop_front();
               if (uo_out[6:0] !== 7'(last_hw)) begin
                  miscompares++;
                  $display("FAIL scoreboard_hw: got %0d, want %0d", uo_out[6:0], last_hw);
               end
            end
         end else begin
            vectors++;
            if (uo_out !== {1'b0, 7'(last_hw)}) begin
               miscompares++;
               $display("FAIL hold_hw: got uo=%h, want %h", uo_out, {1'b0, 7'(last_hw)});
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      ui_in = 8'h00;
      step(2);
      rst_n = 1'b0;
   endtask

   task automatic capture();
      ui_in[1] = 1'b1;
      step(2);
      ui_in[1] = 1'b0;
   endtask

   task automatic wait_valid(input int lo, input int hi, input string nm);
      bit seen;
      int got;
      seen = 1'b0;
      got  = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (uo_out[7] === 1'b1) begin
            seen = 1'b1;
            got  = int'(uo_out[6:0]);
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s: got no valid pulse within 30 cycles, want one", nm);
      end else begin
         if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s_hw: got %0d, want %0d..%0d", nm, got, lo, hi);
         end
         @(negedge clk);
         vectors++;
         if (uo_out !== {1'b0, 7'(got)}) begin
            miscompares++;
            $display("FAIL %s_after: got uo=%h, want %h", nm, uo_out, {1'b0, 7'(got)});
         end
      end
      #1;
   endtask

   initial begin
      int n;
      int w;
      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      step(3);
      ui_in  = 8'h00;
      rst_n  = 1'b0;
      step(3);

      // Bypassed steady one fills the line completely.
      ui_in = 8'h18;
      step(200);
      capture();
      wait_valid(127, 127, "steady_one");

      // ena low between capture and result freezes the pipeline.
      ui_in[1] = 1'b1;
      step(3);
      ena      = 1'b0;
      ui_in[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (uo_out[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL ena_freeze_valid: got valid=%b, want 0", uo_out[7]);
         end
      end
      #1;
      ena = 1'b1;
      wait_valid(127, 127, "ena_freeze");

      // Ones present on exactly 20 shifting edges before the capture edge.
      ui_in = 8'h08;
      step(200);
      ui_in[4] = 1'b1;
      step(18);
      ui_in[1] = 1'b1;
      step(2);
      ui_in[1] = 1'b0;
      wait_valid(20, 20, "twenty_edges");

      // Launch register path: nothing until a launch edge, then the line fills.
      do_reset();
      ui_in = 8'h10;
      step(200);
      capture();
      wait_valid(0, 0, "no_launch");
      ui_in[0] = 1'b1;
      step(2);
      ui_in[0] = 1'b0;
      step(200);
      capture();
      wait_valid(127, 127, "after_launch");

      // Square wave on pg_tog, 2 high / 2 low, captured mid-stream.
      do_reset();
      ui_in = 8'h0C;
      fork
         begin
            for (int i = 0; i < 50; i++) begin
               ui_in[5] = 1'b1;
               step(2);
               ui_in[5] = 1'b0;
               step(2);
            end
         end
         begin
            step(150);
            capture();
            wait_valid(63, 64, "toggle");
         end
      join

      // Reset while a capture is in flight discards it.
      ui_in = 8'h18;
      step(200);
      ui_in[1] = 1'b1;
      step(3);
      rst_n = 1'b1;
      ui_in = 8'h08;
      step(1);
      rst_n = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vectors++;
         if (uo_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_discard: got uo=%h, want 00", uo_out);
         end
      end
      #1;
      step(130);
      capture();
      wait_valid(0, 0, "zero_after_reset");

      // Randomized traffic checked by the scoreboard.
      for (int it = 0; it < 40; it++) begin
         ui_in  = 8'($urandom) & 8'hFC;
         uio_in = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            ui_in[0] = 1'b1;
            step(int'($urandom_range(1, 3)));
            ui_in[0] = 1'b0;
         end
         n = int'($urandom_range(20, 200));
         w = int'($urandom_range(1, 4));
         for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 3) == 0)  ui_in[5] = ~ui_in[5];
            if ($urandom_range(0, 15) == 0) ui_in[4] = ~ui_in[4];
            if ($urandom_range(0, 59) == 0) ui_in[0] = ~ui_in[0];
            if ($urandom_range(0, 40) == 0) ui_in[1] = ~ui_in[1];
            ena = ($urandom_range(0, 9) != 0);
            if (c == n - 10)     ui_in[1] = 1'b1;
            if (c == n - 10 + w) ui_in[1] = 1'b0;
            step(1);
         end
         ena      = 1'b1;
         ui_in[1] = 1'b0;
         step(8);
         if ($urandom_range(0, 9) == 0) do_reset();
      end

      ena   = 1'b1;
      ui_in = 8'h00;
      step(20);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d expected results never presented, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
